// File: rtl/keccak_pkg.sv
// Shared Keccak constants, lane addressing and the squeeze FSM state type.
// Lanes are numbered i = 5*y + x; each lane occupies 64 consecutive state bits.
package keccak_pkg;

  localparam int STATE_W   = 1600;
  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_PERM
  } fsm_t;

  function automatic int unsigned lane_offset(input int unsigned x, input int unsigned y);
    return LANE_W * (5 * y + x);
  endfunction

endpackage

// File: rtl/keccak_lane_sel.sv
// Combinational 25:1 lane multiplexer over the ascending-indexed state vector.
// Output bit z of the lane is state bit lane_offset + z.
module keccak_lane_sel
  import keccak_pkg::*;
(
  input  logic [0:STATE_W-1] i_state,
  input  logic [4:0]         i_idx,
  output logic [LANE_W-1:0]  o_lane
);

  always_comb begin
    o_lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i_idx == 5'(i)) begin
        for (int z = 0; z < LANE_W; z++) begin
          o_lane[z] = i_state[lane_offset(i % 5, i / 5) + z];
        end
      end
    end
  end

endmodule

// File: rtl/keccak_squeeze.sv
// Squeeze phase: streams rate lanes from a held state and requests a fresh
// permutation whenever the rate portion is exhausted before the count is met.
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int RATE_LANES = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [15:0]        i_req_lanes,
  input  logic [0:STATE_W-1] i_state_in,
  output logic [LANE_W-1:0]  o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_out_last,
  output logic               o_perm_req,
  input  logic               i_perm_ack,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  fsm_t               r_fsm;
  logic [0:STATE_W-1] r_state;
  logic [4:0]         r_idx;
  logic [15:0]        r_rem;
  logic               r_valid;
  logic               r_last;
  logic               r_perm_req;
  logic               r_done;
  logic [LANE_W-1:0]  w_lane;

  keccak_lane_sel u_lane_sel (
    .i_state (r_state),
    .i_idx   (r_idx),
    .o_lane  (w_lane)
  );

  // out_data is read straight from the held state; a zeroed state gives zero data in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_state    <= '0;
      r_idx      <= '0;
      r_rem      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_perm_req <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (i_start) begin
            if (i_req_lanes == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= i_state_in;
              r_idx   <= '0;
              r_rem   <= i_req_lanes;
              r_valid <= 1'b1;
              r_last  <= (i_req_lanes == 16'd1);
              r_fsm   <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (r_valid && i_out_ready) begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_fsm   <= ST_IDLE;
            end else if (r_idx == LAST_IDX) begin
              r_valid    <= 1'b0;
              r_last     <= 1'b0;
              r_perm_req <= 1'b1;
              r_fsm      <= ST_PERM;
            end else begin
              r_idx  <= r_idx + 5'd1;
              r_last <= (r_rem == 16'd2);
            end
          end
        end
        ST_PERM: begin
          if (i_perm_ack) begin
            r_state    <= i_state_in;
            r_idx      <= '0;
            r_perm_req <= 1'b0;
            r_valid    <= 1'b1;
            r_last     <= (r_rem == 16'd1);
            r_fsm      <= ST_EMIT;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign o_out_data  = w_lane;
  assign o_out_valid = r_valid;
  assign o_out_last  = r_last;
  assign o_perm_req  = r_perm_req;
  assign o_done      = r_done;
  assign o_busy      = (r_fsm != ST_IDLE);

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: table of squeezes at rates 21 and 17 with random
// data, backpressure and spurious start/ack, plus hand-written reset cases.
module tb_keccak_squeeze;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   reqLanes;
  logic [0:1599] stateIn;
  logic          outReady;
  logic          permAck;
  logic          sel17;

  logic [63:0] d21Data, d17Data, vData;
  logic        d21Valid, d21Last, d21Perm, d21Busy, d21Done;
  logic        d17Valid, d17Last, d17Perm, d17Busy, d17Done;
  logic        vValid, vLast, vPerm, vBusy, vDone;

  always #5 clk = ~clk;

  keccak_squeeze #(.RATE_LANES(21)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_req_lanes(reqLanes),
    .i_state_in(stateIn), .o_out_data(d21Data), .o_out_valid(d21Valid),
    .i_out_ready(outReady), .o_out_last(d21Last), .o_perm_req(d21Perm),
    .i_perm_ack(permAck), .o_busy(d21Busy), .o_done(d21Done)
  );

  keccak_squeeze #(.RATE_LANES(17)) dut17 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_req_lanes(reqLanes),
    .i_state_in(stateIn), .o_out_data(d17Data), .o_out_valid(d17Valid),
    .i_out_ready(outReady), .o_out_last(d17Last), .o_perm_req(d17Perm),
    .i_perm_ack(permAck), .o_busy(d17Busy), .o_done(d17Done)
  );

  assign vData  = sel17 ? d17Data  : d21Data;
  assign vValid = sel17 ? d17Valid : d21Valid;
  assign vLast  = sel17 ? d17Last  : d21Last;
  assign vPerm  = sel17 ? d17Perm  : d21Perm;
  assign vBusy  = sel17 ? d17Busy  : d21Busy;
  assign vDone  = sel17 ? d17Done  : d21Done;

  typedef struct {
    int req;
    bit use17;
    int readyMode;
    int ackDelay;
    bit fixedData;
    int expPerms;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] blockLanes[0:3][0:24];
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:1599] packState(input int b);
    logic [0:1599] s;
    for (int i = 0; i < 25; i++)
      for (int z = 0; z < 64; z++)
        s[64*i + z] = blockLanes[b][i][z];
    return s;
  endfunction

  function automatic logic [0:1599] junkState();
    logic [0:1599] s;
    for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; permAck = 1'b0; outReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete squeeze; expected lane k comes from block k/rate, lane k%rate.
  task automatic applyStimulus(input vec_t v);
    int  rate, xfers, perms, waitCnt, blk, cyc;
    bit  finished, stalled, prevPerm;
    logic [63:0] heldData, expLane;
    logic heldLast;
    logic [3:0] pat;
    rate = v.use17 ? 17 : 21;
    pat = 4'b1001;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 25; i++)
        blockLanes[b][i] = v.fixedData ? (64'h0101010101010101 * 64'(i + 25*b))
                                       : {$urandom, $urandom};
    sel17 = v.use17;
    start = 1'b1; reqLanes = 16'(v.req); stateIn = packState(0);
    @(negedge clk);
    start = 1'b0; stateIn = junkState();
    checkOutput("first_valid", 64'(vValid), 64'd1);
    xfers = 0; perms = 0; waitCnt = 0; blk = 0; cyc = 0;
    finished = 0; stalled = 0; prevPerm = 0; heldData = '0; heldLast = 0;
    while (!finished && cyc < 3000) begin
      cyc++;
      if (stalled) begin
        checkOutput("stall_valid", 64'(vValid), 64'd1);
        checkOutput("stall_data", vData, heldData);
        checkOutput("stall_last", 64'(vLast), 64'(heldLast));
      end
      if (vPerm && !prevPerm) begin
        perms++;
        waitCnt = 0;
      end
      prevPerm = vPerm;
      if (vPerm) begin
        if (waitCnt == v.ackDelay && blk < 3) begin
          permAck = 1'b1; blk++; stateIn = packState(blk);
        end else begin
          permAck = 1'b0; stateIn = junkState();
        end
        waitCnt++;
      end else begin
        permAck = ($urandom_range(0, 3) == 0);
        stateIn = junkState();
      end
      case (v.readyMode)
        0:       outReady = 1'b1;
        1:       outReady = pat[3 - ((cyc - 1) % 4)];
        default: outReady = ($urandom_range(0, 9) < 7);
      endcase
      if (vValid && outReady) begin
        expLane = (xfers / rate < 4) ? blockLanes[xfers / rate][xfers % rate] : '0;
        checkOutput("lane_data", vData, expLane);
        checkOutput("lane_last", 64'(vLast), 64'(xfers == v.req - 1));
        xfers++;
        stalled = 0;
        if (xfers == v.req) finished = 1;
      end else begin
        stalled = vValid;
        heldData = vData;
        heldLast = vLast;
      end
      start = (!finished && $urandom_range(0, 4) == 0);
      reqLanes = 16'($urandom_range(0, 60));
      @(negedge clk);
    end
    start = 1'b0; permAck = 1'b0; outReady = 1'b0;
    if (!finished) checkOutput("squeeze_timeout", 64'd0, 64'd1);
    checkOutput("done_pulse", 64'(vDone), 64'd1);
    checkOutput("valid_after_done", 64'(vValid), 64'd0);
    checkOutput("busy_after_done", 64'(vBusy), 64'd0);
    checkOutput("transfer_count", 64'(xfers), 64'(v.req));
    checkOutput("perm_episodes", 64'(perms), 64'(v.expPerms));
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(vDone), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4,  0, 0, 0, 1, 0};
    vecs[1]  = '{23, 0, 0, 5, 0, 1};
    vecs[2]  = '{3,  0, 1, 0, 0, 0};
    vecs[3]  = '{9,  0, 2, 0, 0, 0};
    vecs[4]  = '{34, 1, 2, 3, 0, 1};
    vecs[5]  = '{35, 1, 2, 1, 0, 2};
    vecs[6]  = '{1,  0, 2, 0, 0, 0};
    vecs[7]  = '{21, 0, 2, 0, 0, 0};
    vecs[8]  = '{22, 0, 0, 0, 0, 1};
    vecs[9]  = '{43, 0, 2, 4, 0, 2};
    vecs[10] = '{17, 1, 0, 2, 0, 0};
    vecs[11] = '{18, 1, 1, 0, 0, 1};

    sel17 = 1'b0; start = 1'b0; reqLanes = '0; stateIn = '0;
    outReady = 1'b0; permAck = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", 64'(vValid), 64'd0);
    checkOutput("reset_data", vData, 64'd0);
    checkOutput("reset_flags", 64'({vLast, vPerm, vBusy, vDone}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k]);
      pulseReset();
    end

    // Zero-length request completes at once without emitting anything.
    sel17 = 1'b0;
    start = 1'b1; reqLanes = 16'd0; stateIn = junkState();
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_done", 64'(vDone), 64'd1);
    checkOutput("zero_valid", 64'(vValid), 64'd0);
    checkOutput("zero_busy", 64'(vBusy), 64'd0);
    @(negedge clk);
    checkOutput("zero_done_clear", 64'(vDone), 64'd0);

    // Reset while waiting for a permutation abandons the squeeze.
    for (int i = 0; i < 25; i++) blockLanes[0][i] = {$urandom, $urandom};
    start = 1'b1; reqLanes = 16'd30; stateIn = packState(0);
    @(negedge clk);
    start = 1'b0; outReady = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && !vPerm; c++) begin
      if (vValid) n++;
      @(negedge clk);
    end
    checkOutput("rst_pre_xfers", 64'(n), 64'd21);
    checkOutput("rst_pre_perm", 64'(vPerm), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_flags", 64'({vValid, vLast, vPerm, vBusy, vDone}), 64'd0);
    checkOutput("rst_mid_data", vData, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; permAck = 1'b1; stateIn = junkState();
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (vValid || vDone || vBusy || vPerm) n++;
    end
    checkOutput("rst_stays_idle", 64'(n), 64'd0);
    permAck = 1'b0; outReady = 1'b0;

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
